// File: rtl/fb_pkg.sv
// Shared parameters and types for the filterbank output path.
// Band samples are sfix37_En32; the serializer emits sfix16_En14.
package fb_pkg;

    localparam int NUM_BANDS = 16;
    localparam int IN_W      = 37;
    localparam int IN_FRAC   = 32;
    localparam int OUT_W     = 16;
    localparam int OUT_FRAC  = 14;
    localparam int SHIFT     = IN_FRAC - OUT_FRAC;
    localparam int BAND_W    = $clog2(NUM_BANDS);
    localparam int DROP_W    = 8;

    typedef logic signed [IN_W-1:0]  band_sample_t;
    typedef logic signed [OUT_W-1:0] out_sample_t;

    typedef struct packed {
        out_sample_t y;
        logic        sat;
    } requant_t;

    typedef enum logic {
        IDLE,
        STREAM
    } ser_state_t;

endpackage

// File: rtl/fb_requant_sat.sv
// Combinational requantizer: round half toward +inf, arithmetic shift by SHIFT,
// then saturate to the signed OUT_W range.
module fb_requant_sat
    import fb_pkg::*;
(
    input  logic signed [IN_W-1:0] sample_i,
    output requant_t               res_o
);

    localparam logic signed [IN_W:0] ROUND = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [IN_W:0] MAXV  = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] MINV  = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [IN_W:0] rounded;
    logic signed [IN_W:0] shifted;

    // One guard bit keeps the rounding add from wrapping at the positive limit.
    always_comb begin
        rounded = {sample_i[IN_W-1], sample_i} + ROUND;
        shifted = rounded >>> SHIFT;
        res_o.sat = 1'b0;
        res_o.y   = shifted[OUT_W-1:0];
        if (shifted > MAXV) begin
            res_o.sat = 1'b1;
            res_o.y   = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (shifted < MINV) begin
            res_o.sat = 1'b1;
            res_o.y   = {1'b1, {(OUT_W-1){1'b0}}};
        end
    end

endmodule

// File: rtl/band_output_serializer.sv
// Double-buffered capture of a full band frame, streamed one requantized band per
// valid/ready beat with registered outputs and a sticky drop indicator.
module band_output_serializer
    import fb_pkg::*;
(
    input  logic                             clk_en,
    input  logic                             reset,
    input  logic                             frame_valid,
    input  logic [NUM_BANDS-1:0][IN_W-1:0]   band_in,
    output logic [OUT_W-1:0]                 out_data,
    output logic [BAND_W-1:0]                out_band,
    output logic                             out_last,
    output logic                             out_sat,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             overflow,
    output logic [DROP_W-1:0]                drop_count
);

    band_sample_t      bank_q [2][NUM_BANDS];
    ser_state_t        state_q, state_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        fill_q, fill_d;
    logic [BAND_W-1:0] cnt_q, cnt_d;
    out_sample_t       data_q;
    logic              sat_q;
    logic              overflow_q;
    logic [DROP_W-1:0] drop_q;

    logic              hs, last_hs, capture, drop, load;
    logic              ld_bank;
    logic [BAND_W-1:0] ld_idx;
    band_sample_t      ld_sample;
    requant_t          rq;

    // The element loaded next may sit in the bank being written this very cycle,
    // so it is taken straight from band_in in that case.
    always_comb begin
        hs       = (state_q == STREAM) && out_ready;
        last_hs  = hs && (cnt_q == BAND_W'(NUM_BANDS - 1));
        capture  = frame_valid && ((fill_q != 2'd2) || last_hs);
        drop     = frame_valid && !capture;
        fill_d   = fill_q + {1'b0, capture} - {1'b0, last_hs};
        wr_ptr_d = wr_ptr_q ^ capture;
        rd_ptr_d = rd_ptr_q ^ last_hs;
        state_d  = state_q;
        cnt_d    = cnt_q;
        load     = 1'b0;
        ld_bank  = rd_ptr_q;
        ld_idx   = cnt_q;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d = STREAM;
                    load    = 1'b1;
                    ld_idx  = '0;
                end
            end
            STREAM: begin
                if (last_hs) begin
                    cnt_d = '0;
                    if (fill_d == 2'd0) begin
                        state_d = IDLE;
                    end else begin
                        load    = 1'b1;
                        ld_bank = ~rd_ptr_q;
                        ld_idx  = '0;
                    end
                end else if (hs) begin
                    cnt_d  = cnt_q + 1'b1;
                    load   = 1'b1;
                    ld_idx = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        ld_sample = (capture && (wr_ptr_q == ld_bank)) ? band_sample_t'(band_in[ld_idx])
                                                        : bank_q[ld_bank][ld_idx];
    end

    fb_requant_sat u_requant (
        .sample_i (ld_sample),
        .res_o    (rq)
    );

    always_ff @(posedge clk_en) begin
        if (capture && !reset) begin
            for (int k = 0; k < NUM_BANDS; k++) begin
                bank_q[wr_ptr_q][k] <= band_in[k];
            end
        end
    end

    always_ff @(posedge clk_en) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fill_q     <= 2'd0;
            cnt_q      <= '0;
            data_q     <= '0;
            sat_q      <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            cnt_q    <= cnt_d;
            if (load) begin
                data_q <= rq.y;
                sat_q  <= rq.sat;
            end
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_q != {DROP_W{1'b1}}) begin
                    drop_q <= drop_q + 1'b1;
                end
            end
        end
    end

    assign out_valid  = (state_q == STREAM);
    assign out_data   = data_q;
    assign out_band   = cnt_q;
    assign out_last   = (state_q == STREAM) && (cnt_q == BAND_W'(NUM_BANDS - 1));
    assign out_sat    = sat_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_band_output_serializer.sv
// Self-checking bench for band_output_serializer: directed scenarios plus a long
// randomized run, all checked against a queue-based reference of expected beats.
module tb_band_output_serializer;
    import fb_pkg::*;

    typedef struct {
        longint data;
        int     band;
        bit     last;
        bit     sat;
    } beat_t;

    logic                           clkEn = 1'b0;
    logic                           reset = 1'b1;
    logic                           frameValid = 1'b0;
    logic [NUM_BANDS-1:0][IN_W-1:0] bandIn = '0;
    logic                           outReady = 1'b0;
    logic [OUT_W-1:0]               outData;
    logic [BAND_W-1:0]              outBand;
    logic                           outLast, outSat, outValid, overflow;
    logic [DROP_W-1:0]              dropCount;

    int    checks = 0;
    int    failures = 0;
    beat_t expQ[$];
    bit    ovModel = 1'b0;
    int    dropModel = 0;

    band_output_serializer dut (
        .clk_en      (clkEn),
        .reset       (reset),
        .frame_valid (frameValid),
        .band_in     (bandIn),
        .out_data    (outData),
        .out_band    (outBand),
        .out_last    (outLast),
        .out_sat     (outSat),
        .out_valid   (outValid),
        .out_ready   (outReady),
        .overflow    (overflow),
        .drop_count  (dropCount)
    );

    always #5 clkEn = ~clkEn;

    // Reference requantizer straight from the arithmetic rule, independent of bit widths in the RTL.
    function automatic beat_t refBeat(input logic [IN_W-1:0] x, input int k);
        beat_t  b;
        longint xv = longint'($signed(x));
        longint y  = (xv + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;
        b.band = k;
        b.last = (k == NUM_BANDS - 1);
        b.sat  = 1'b0;
        b.data = y;
        if (y > 32767) begin
            b.data = 32767;
            b.sat  = 1'b1;
        end else if (y < -32768) begin
            b.data = -32768;
            b.sat  = 1'b1;
        end
        return b;
    endfunction

    task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                               input logic signed [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic reportTimeout(input string tag);
        checks++;
        failures++;
        $error("[TB] FAIL %s observed=timeout expected=condition reached", tag);
    endtask

    // One clock: model predicts handshake/capture/drop, then the DUT is compared after the edge.
    task automatic applyStimulus(input bit fv, input bit rdy, input bit rst);
        bit hs, lastHs, cap;
        int outstanding;
        hs          = (expQ.size() > 0) && rdy && !rst;
        lastHs      = hs && expQ[0].last;
        outstanding = (expQ.size() + NUM_BANDS - 1) / NUM_BANDS;
        cap         = fv && !rst && ((outstanding < 2) || lastHs);
        frameValid  = fv;
        outReady    = rdy;
        reset       = rst;
        @(posedge clkEn);
        #1;
        frameValid = 1'b0;
        reset      = 1'b0;
        if (rst) begin
            expQ.delete();
            ovModel   = 1'b0;
            dropModel = 0;
        end else begin
            if (hs) void'(expQ.pop_front());
            if (cap) begin
                for (int k = 0; k < NUM_BANDS; k++) expQ.push_back(refBeat(bandIn[k], k));
            end else if (fv) begin
                ovModel = 1'b1;
                if (dropModel < 255) dropModel++;
            end
        end
        checkOutput("out_valid", outValid, expQ.size() > 0);
        if (expQ.size() > 0) begin
            checkOutput("out_data", $signed(outData), expQ[0].data);
            checkOutput("out_band", outBand, expQ[0].band);
            checkOutput("out_last", outLast, expQ[0].last);
            checkOutput("out_sat", outSat, expQ[0].sat);
        end
        checkOutput("overflow", overflow, ovModel);
        checkOutput("drop_count", dropCount, dropModel);
    endtask

    task automatic randomFrame();
        longint v;
        for (int k = 0; k < NUM_BANDS; k++) begin
            v = longint'({$urandom, $urandom});
            v = v >>> $urandom_range(27, 63);
            bandIn[k] = v[IN_W-1:0];
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_valid"}, outValid, 0);
        checkOutput({tag, "_data"}, outData, 0);
        checkOutput({tag, "_band"}, outBand, 0);
        checkOutput({tag, "_last"}, outLast, 0);
        checkOutput({tag, "_sat"}, outSat, 0);
        checkOutput({tag, "_ovf"}, overflow, 0);
        checkOutput({tag, "_drops"}, dropCount, 0);
    endtask

    initial begin
        int budget;
        longint rv;

        // Reset with a frame strobe held high: it must be ignored.
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkAllZero("reset");

        // Integer ramp: band k carries k in sfix37_En32.
        for (int k = 0; k < NUM_BANDS; k++) bandIn[k] = IN_W'(longint'(k) <<< 32);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("ramp_beat0", $signed(outData), 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("ramp_beat1", $signed(outData), 16384);
        checkOutput("ramp_sat1", outSat, 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("ramp_beat2", $signed(outData), 32767);
        checkOutput("ramp_sat2", outSat, 1);
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 1'b0);

        // Rounding corners around half an output LSB, and a negative saturation.
        bandIn = '0;
        rv = 64'sd1 <<< 17;        bandIn[0] = rv[IN_W-1:0];
        rv = (64'sd1 <<< 17) - 1;  bandIn[1] = rv[IN_W-1:0];
        rv = -(64'sd1 <<< 17);     bandIn[2] = rv[IN_W-1:0];
        rv = -(64'sd1 <<< 17) - 1; bandIn[3] = rv[IN_W-1:0];
        rv = -(64'sd1 <<< 34);     bandIn[4] = rv[IN_W-1:0];
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("round_p_half", $signed(outData), 1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("round_p_below", $signed(outData), 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("round_n_half", $signed(outData), 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("round_n_below", $signed(outData), -1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("round_n_sat", $signed(outData), -32768);
        checkOutput("round_n_sat_flag", outSat, 1);
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 1'b0);

        // Stalled consumer: two frames buffer, the third is dropped.
        for (int f = 0; f < 3; f++) begin
            randomFrame();
            applyStimulus(1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 58; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        end
        checkOutput("stall_overflow", overflow, 1);
        checkOutput("stall_drops", dropCount, 1);
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("stall_drained", outValid, 0);

        // Reset while beat 7 of a frame is on the bus.
        randomFrame();
        applyStimulus(1'b1, 1'b1, 1'b0);
        budget = 30;
        while (!(expQ.size() > 0 && expQ[0].band == 7) && budget > 0) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            budget--;
        end
        if (budget == 0) reportTimeout("midreset_wait");
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkAllZero("midreset");
        applyStimulus(1'b0, 1'b1, 1'b0);
        randomFrame();
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("midreset_restart_band", outBand, 0);
        checkOutput("midreset_restart_valid", outValid, 1);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 1'b0);

        // Both banks full; a new frame arrives exactly on the freeing last-beat handshake.
        randomFrame();
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        randomFrame();
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        budget = 40;
        while (!(expQ.size() == NUM_BANDS + 1 && expQ[0].last) && budget > 0) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            budget--;
        end
        if (budget == 0) reportTimeout("freeing_wait");
        randomFrame();
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("freeing_no_drop", dropCount, 0);
        checkOutput("freeing_no_ovf", overflow, 0);
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b1, 1'b0);

        // Long run at the nominal frame period with a randomly stalling consumer.
        for (int f = 0; f < 1000; f++) begin
            randomFrame();
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            for (int i = 0; i < 58; i++) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end
        for (int i = 0; i < 60; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("random_no_ovf", overflow, 0);
        checkOutput("random_no_drops", dropCount, 0);
        checkOutput("random_drained", outValid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
